// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin owner of a 4:1 mux; ports clk, reset_n (sync, low), req[3:0] in; gnt[3:0], s1/s0 selects, busy, preempt out (all registered)
module mux4_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       preempt
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [CNT_W-1:0] HM = CNT_W'(HOLD_MAX);
  state_t           r_state, w_state_n;
  logic [3:0]       r_gnt, w_gnt_n;
  logic [1:0]       r_sel, w_sel_n, r_last, w_last_n, w_win;
  logic             r_busy, w_busy_n, r_pre, w_pre_n, w_cap;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  // scan from lowest to highest priority so the highest-priority hit is written last
  always_comb begin
    w_win = r_last;
    for (int k = 3; k >= 0; k--)
      if (req[2'(r_last + 2'(k + 1))]) w_win = 2'(r_last + 2'(k + 1));
  end
  assign w_cap = (HOLD_MAX != 0) && (r_cnt == HM);
  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_sel_n   = r_sel;
    w_busy_n  = r_busy;
    w_pre_n   = 1'b0;
    w_last_n  = r_last;
    w_cnt_n   = r_cnt;
    if (r_state == IDLE) begin
      if (|req) begin
        w_state_n = GRANT;
        w_gnt_n   = 4'b0001 << w_win;
        w_sel_n   = w_win;
        w_busy_n  = 1'b1;
        w_last_n  = w_win;
        w_cnt_n   = CNT_W'(1);
      end
    end else if (!req[r_sel] || w_cap) begin
      w_state_n = IDLE;
      w_gnt_n   = '0;
      w_busy_n  = 1'b0;
      w_pre_n   = req[r_sel];
    end else begin
      w_cnt_n = &r_cnt ? r_cnt : r_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_pre   <= 1'b0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_sel   <= w_sel_n;
      r_busy  <= w_busy_n;
      r_pre   <= w_pre_n;
      r_last  <= w_last_n;
      r_cnt   <= w_cnt_n;
    end
  end
  assign gnt     = r_gnt;
  assign {s1, s0} = r_sel;
  assign busy    = r_busy;
  assign preempt = r_pre;
endmodule
